// File: rtl/pwm_sine_multi.sv
// pwm_sine_multi: multi-channel DDS waveform generator with PWM outputs.
// Every channel has its own phase accumulator, frequency word, duty,
// waveform mode (off / sine / square / sawtooth) and enable. All channels
// share one free-running PWM period counter. The accumulator steps and the
// duty is reloaded once per period. A 3-byte command stream (header, data
// high byte, data low byte) from a UART byte interface writes the
// per-channel registers.
// Ports:
//   clk1        system clock
//   rst         asynchronous active-high reset
//   rx_valid    one-cycle strobe, rx_data is valid
//   rx_data     received byte
//   pwm_out     registered PWM output, one bit per channel
//   period_sync one-cycle pulse aligned with the last output clock of a period
//   cmd_done    one-cycle pulse when a command is committed
//   cmd_err     one-cycle pulse when a command is discarded (bad channel/timeout)
module pwm_sine_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned ACC_BITS = 16,
  parameter int unsigned LUT_BITS = 6,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_sync,
  output logic                cmd_done,
  output logic                cmd_err
);

  localparam int unsigned LUT_SIZE = 2 ** LUT_BITS;
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam real         PI       = 3.14159265358979323846;
  localparam real         AMP      = real'((1 << (PWM_BITS - 1)) - 1);
  localparam logic [PWM_BITS-1:0] HALF    = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] HALF_M1 = {1'b0, {(PWM_BITS-1){1'b1}}};

  // Quarter-wave magnitude table, sampled at bin centres so the mirrored
  // quadrants never repeat the peak or zero sample.
  logic [PWM_BITS-1:0] mag_rom [LUT_SIZE];

  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_rom
    localparam int MAG = $rtoi(AMP * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(LUT_SIZE)) + 0.5);
    assign mag_rom[k] = MAG[PWM_BITS-1:0];
  end

  // Shared period counter
  logic [PWM_BITS-1:0] cnt;
  logic                wrap;

  assign wrap = (cnt == '1);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      period_sync <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      period_sync <= wrap;
    end
  end

  // Command parser
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t          state;
  logic [1:0]      reg_sel;
  logic [4:0]      ch_sel;
  logic [7:0]      data_hi;
  logic [TW-1:0]   idle_cnt;
  logic            commit;
  logic            ch_ok;
  logic            wr_en;
  logic [15:0]     wr_data;

  always_comb begin
    commit  = (state == LO) && rx_valid;
    ch_ok   = ({1'b0, ch_sel} < 6'(CHANNELS));
    wr_en   = commit && ch_ok;
    wr_data = {data_hi, rx_data};
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      reg_sel  <= '0;
      ch_sel   <= '0;
      data_hi  <= '0;
      idle_cnt <= '0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_done <= wr_en;
      cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (rx_valid && rx_data[7]) begin
            reg_sel <= rx_data[6:5];
            ch_sel  <= rx_data[4:0];
            state   <= HI;
          end
        end
        HI, LO: begin
          // Inside a command every byte is data, even one with bit 7 set.
          if (rx_valid) begin
            idle_cnt <= '0;
            if (state == HI) begin
              data_hi <= rx_data;
              state   <= LO;
            end else begin
              cmd_err <= !ch_ok;
              state   <= IDLE;
            end
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            cmd_err  <= 1'b1;
            idle_cnt <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel datapath
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_BITS-1:0]   acc;
    logic [ACC_BITS-1:0]   freq;
    logic [PWM_BITS-1:0]   duty;
    logic [PWM_BITS-1:0]   wave;
    logic [PWM_BITS-1:0]   mag;
    logic [LUT_BITS+1:0]   p;
    logic [LUT_BITS-1:0]   idx;
    logic [1:0]            mode;
    logic                  enable;
    logic                  sel;
    logic                  pwm_q;

    assign sel        = wr_en && (ch_sel == 5'(c));
    assign pwm_out[c] = pwm_q;

    always_comb begin
      p    = acc[ACC_BITS-1 -: LUT_BITS+2];
      idx  = p[LUT_BITS] ? ~p[LUT_BITS-1:0] : p[LUT_BITS-1:0];
      mag  = mag_rom[idx];
      wave = '0;
      case (mode)
        2'b01:   wave = p[LUT_BITS+1] ? (HALF_M1 - mag) : (HALF + mag);
        2'b10:   wave = acc[ACC_BITS-1] ? '0 : '1;
        2'b11:   wave = acc[ACC_BITS-1 -: PWM_BITS];
        default: wave = '0;
      endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
        acc    <= '0;
        freq   <= '0;
        duty   <= '0;
        mode   <= '0;
        enable <= 1'b0;
        pwm_q  <= 1'b0;
      end else begin
        if (wrap) begin
          duty <= wave;
          acc  <= acc + freq;
        end
        // A phase write issued on a wrap overrides the accumulator step
        // because it is the later assignment; duty still used the old acc.
        if (sel) begin
          case (reg_sel)
            2'b00: freq   <= wr_data[ACC_BITS-1:0];
            2'b01: mode   <= wr_data[1:0];
            2'b10: acc    <= wr_data[15 -: ACC_BITS];
            2'b11: enable <= wr_data[0];
            default: ;
          endcase
        end
        pwm_q <= enable & (cnt < duty);
      end
    end
  end

endmodule

// File: tb/tb_pwm_sine_multi.sv
// Testbench for pwm_sine_multi: directed command sequence plus randomized
// channel configurations, compared every clock against a behavioural model
// whose waveform values are computed from real-valued sine arithmetic.
module tb_pwm_sine_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned TO = 300;
  localparam real         PI = 3.14159265358979323846;

  logic          clk1 = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [CH-1:0] pwm_out;
  logic          period_sync;
  logic          cmd_done;
  logic          cmd_err;

  pwm_sine_multi #(
    .CHANNELS(CH),
    .PWM_BITS(8),
    .ACC_BITS(16),
    .LUT_BITS(6),
    .TIMEOUT(TO)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pwm_out    (pwm_out),
    .period_sync(period_sync),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err)
  );

  always #5 clk1 = ~clk1;

  int compared = 0;
  int mismatched = 0;

  // Model state
  int unsigned   m_cnt;
  int unsigned   m_acc  [CH];
  int unsigned   m_freq [CH];
  int unsigned   m_duty [CH];
  logic [1:0]    m_mode [CH];
  bit            m_en   [CH];
  logic [CH-1:0] exp_pwm;
  bit            exp_sync, exp_done, exp_err;
  bit            pend_cmd, pend_to;
  logic [7:0]    pend_hdr;
  logic [15:0]   pend_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, expv);
    end
  endtask

  function automatic int unsigned model_wave(input int unsigned acc, input logic [1:0] mode);
    int unsigned p, q, i, idx, mag;
    p   = acc >> 8;
    q   = p >> 6;
    i   = p % 64;
    idx = (q % 2 == 1) ? 63 - i : i;
    mag = $rtoi(127.0 * $sin(PI / 2.0 * (real'(idx) + 0.5) / 64.0) + 0.5);
    case (mode)
      2'd1:    return (q >= 2) ? 127 - mag : 128 + mag;
      2'd2:    return (acc < 32768) ? 255 : 0;
      2'd3:    return acc >> 8;
      default: return 0;
    endcase
  endfunction

  task automatic reset_model();
    m_cnt = 0;
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_freq[c] = 0; m_duty[c] = 0; m_mode[c] = 2'd0; m_en[c] = 1'b0;
    end
    exp_pwm = '0; exp_sync = 0; exp_done = 0; exp_err = 0;
    pend_cmd = 0; pend_to = 0;
  endtask

  // One clock: predict next outputs, advance the clock, compare.
  task automatic tick();
    int unsigned ch;
    for (int c = 0; c < CH; c++) exp_pwm[c] = m_en[c] && (m_cnt < m_duty[c]);
    exp_sync = (m_cnt == 255);
    exp_done = 0;
    exp_err  = pend_to;
    if (m_cnt == 255) begin
      for (int c = 0; c < CH; c++) begin
        m_duty[c] = model_wave(m_acc[c], m_mode[c]);
        m_acc[c]  = (m_acc[c] + m_freq[c]) % 65536;
      end
    end
    if (pend_cmd) begin
      ch = pend_hdr[4:0];
      if (ch < CH) begin
        exp_done = 1;
        case (pend_hdr[6:5])
          2'd0: m_freq[ch] = pend_data;
          2'd1: m_mode[ch] = pend_data[1:0];
          2'd2: m_acc[ch]  = pend_data;
          default: m_en[ch] = pend_data[0];
        endcase
      end else begin
        exp_err = 1;
      end
    end
    pend_cmd = 0;
    pend_to  = 0;
    @(posedge clk1);
    #1;
    m_cnt = (m_cnt + 1) % 256;
    check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check("period_sync", 32'(period_sync), 32'(exp_sync));
    check("cmd_done", 32'(cmd_done), 32'(exp_done));
    check("cmd_err", 32'(cmd_err), 32'(exp_err));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic align(input int unsigned target);
    while (m_cnt != target) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] hdr, input logic [15:0] data);
    rx_valid = 1'b1;
    rx_data  = hdr;
    tick();
    rx_data  = data[15:8];
    tick();
    rx_data  = data[7:0];
    pend_cmd = 1; pend_hdr = hdr; pend_data = data;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] hdr_of(input int unsigned rg, input int unsigned c);
    return 8'(32'h80 | (rg << 5) | c);
  endfunction

  initial begin
    int unsigned hi, c, gap;
    int unsigned bases [4];
    bases[0] = 32'h3F00; bases[1] = 32'h7F00; bases[2] = 32'hBF00; bases[3] = 32'hFF00;

    // Power-on reset
    reset_model();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_sync", 32'(period_sync), 32'h0);
    check("reset_done", 32'(cmd_done), 32'h0);
    check("reset_err", 32'(cmd_err), 32'h0);
    rst = 1'b0;

    // Idle after reset, stray non-header byte ignored
    run(40);
    send_byte(8'h12);
    run(3 * 256);

    // ch0: enable, sine, phase 90 degrees, freq 0 -> duty 255
    send_cmd(hdr_of(3, 0), 16'h0001);
    send_cmd(hdr_of(1, 0), 16'h0001);
    send_cmd(hdr_of(2, 0), 16'h4000);
    send_cmd(hdr_of(0, 0), 16'h0000);
    run(2 * 256);
    hi = 0;
    repeat (256) begin
      tick();
      hi += 32'(pwm_out[0]);
    end
    check("ch0_high_clocks", hi, 255);

    // ch1: square, freq 0x0100, started close to the half-cycle edge
    send_cmd(hdr_of(1, 1), 16'h0002);
    send_cmd(hdr_of(0, 1), 16'h0100);
    send_cmd(hdr_of(2, 1), 16'h7E00);
    send_cmd(hdr_of(3, 1), 16'h0001);
    run(6 * 256);

    // Out-of-range channel 31
    send_cmd(8'h9F, 16'h1234);
    run(300);

    // ch3 sawtooth; freq data high byte looks like a header
    send_cmd(hdr_of(1, 3), 16'h0003);
    send_cmd(hdr_of(3, 3), 16'h0001);
    send_cmd(hdr_of(0, 3), 16'hA1B2);
    run(3 * 256);

    // Timeout after header + one data byte, then a normal command
    rx_valid = 1'b1; rx_data = hdr_of(0, 2);
    tick();
    rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    run(TO - 1);
    pend_to = 1;
    tick();
    run(5);
    send_cmd(hdr_of(0, 2), 16'h0040);
    run(256);

    // Phase and freq writes landing exactly on the wrap edge
    align(253);
    send_cmd(hdr_of(2, 3), 16'h1234);
    align(253);
    send_cmd(hdr_of(0, 3), 16'h0800);
    run(3 * 256);

    // Reset mid-period and mid-command
    align(100);
    rx_valid = 1'b1; rx_data = hdr_of(2, 0);
    tick();
    rx_data = 8'h12;
    tick();
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset_pwm", 32'(pwm_out), 32'h0);
    check("async_reset_sync", 32'(period_sync), 32'h0);
    reset_model();
    repeat (2) @(posedge clk1);
    #2 rst = 1'b0;
    send_byte(8'h34);
    run(3 * 256);

    // Sine on ch2 across every quadrant boundary, freq 0x0040
    send_cmd(hdr_of(1, 2), 16'h0001);
    send_cmd(hdr_of(0, 2), 16'h0040);
    send_cmd(hdr_of(3, 2), 16'h0001);
    for (int b = 0; b < 4; b++) begin
      send_cmd(hdr_of(2, 2), 16'(bases[b]));
      run(8 * 256);
    end
    run(32 * 256);

    // Randomized configurations
    repeat (8) begin
      c = $urandom_range(0, CH - 1);
      send_cmd(hdr_of(1, c), 16'($urandom_range(0, 3)));
      send_cmd(hdr_of(0, c), 16'($urandom));
      send_cmd(hdr_of(2, c), 16'($urandom));
      send_cmd(hdr_of(3, c), 16'($urandom_range(0, 1)));
      gap = $urandom_range(0, 40);
      run(int'(gap));
      run(2 * 256);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
